// File: rtl/cache_snoop_responder_pkg.sv
// ============================================================================
// Module      : cache_snoop_responder_pkg
// Description : Shared coherence-bus types for the snoop responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_snoop_responder_pkg;

    typedef enum logic [1:0] {
        NOOP       = 2'd0,
        READ_MISS  = 2'd1,
        WRITE_MISS = 2'd2,
        INVALIDATE = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } cache_block_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WB     = 2'd2,
        ACK    = 2'd3
    } snoop_fsm_t;

    localparam int C_ADDR_W  = 16;
    localparam int C_DATA_W  = 16;
    localparam int C_STAT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/snoop_stat_ctr.sv
// ============================================================================
// Module      : snoop_stat_ctr
// Description : 16-bit saturating event counter for snoop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snoop_stat_ctr
    import cache_snoop_responder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    output logic [C_STAT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {C_STAT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_snoop_responder.sv
// ============================================================================
// Module      : cache_snoop_responder
// Description : Snoop side of the coherence bus; downgrades/invalidates local
//               blocks and writes back dirty data. Optional statistics
//               counters are enabled by defining SNOOP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_snoop_responder
    import cache_snoop_responder_pkg::*;
#(
    parameter int         INDEX_W = 4,
    parameter int         TAG_W   = 12,
    parameter logic [1:0] CORE_ID = 2'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_valid,
    input  bus_op_t                 bus_op,
    input  logic [C_ADDR_W-1:0]     bus_addr,
    input  logic [1:0]              bus_src_id,
    output logic                    bus_ack,
    output logic                    snp_hit,
    output logic                    snp_flush,
    output logic                    snp_busy,
    output logic                    tag_rd_en,
    output logic [INDEX_W-1:0]      tag_rd_idx,
    input  logic [TAG_W-1:0]        tag_rd_tag,
    input  cache_block_state_t      tag_rd_state,
    input  logic [C_DATA_W-1:0]     tag_rd_data,
    output logic                    st_wr_en,
    output logic [INDEX_W-1:0]      st_wr_idx,
    output cache_block_state_t      st_wr_state,
    output logic                    wb_req,
    output logic [C_ADDR_W-1:0]     wb_addr,
    output logic [C_DATA_W-1:0]     wb_data,
    input  logic                    wb_ack,
    output logic                    err_proto
`ifdef SNOOP_STATS_EN
    ,
    output logic [C_STAT_W-1:0]     stat_hits,
    output logic [C_STAT_W-1:0]     stat_flushes
`endif
);

    snoop_fsm_t          r_state;
    bus_op_t             r_op;
    logic [C_ADDR_W-1:0] r_addr;
    cache_block_state_t  r_pend;

    logic w_foreign;
    logic w_hit;

    assign w_foreign  = bus_valid && (bus_op != NOOP) && (bus_src_id != CORE_ID);
    assign w_hit      = (tag_rd_tag == r_addr[C_ADDR_W-1:INDEX_W]) && (tag_rd_state != INVALID);

    assign snp_busy   = (r_state != IDLE);
    assign tag_rd_en  = (r_state == IDLE) && w_foreign;
    assign tag_rd_idx = bus_addr[INDEX_W-1:0];
    assign st_wr_idx  = r_addr[INDEX_W-1:0];

    // State writes fire in the deciding cycle so they never coincide with bus_ack
    // and vanish immediately if reset forces the FSM back to IDLE.
    always_comb begin
        st_wr_en    = 1'b0;
        st_wr_state = INVALID;
        err_proto   = 1'b0;
        if ((r_state == LOOKUP) && w_hit) begin
            if ((tag_rd_state == SHARED) && (r_op != READ_MISS)) begin
                st_wr_en = 1'b1;
            end else if ((tag_rd_state == MODIFIED) && (r_op == INVALIDATE)) begin
                st_wr_en  = 1'b1;
                err_proto = 1'b1;
            end
        end else if ((r_state == WB) && wb_ack) begin
            st_wr_en    = 1'b1;
            st_wr_state = r_pend;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= NOOP;
            r_addr    <= '0;
            r_pend    <= INVALID;
            bus_ack   <= 1'b0;
            snp_hit   <= 1'b0;
            snp_flush <= 1'b0;
            wb_req    <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            bus_ack   <= 1'b0;
            snp_hit   <= 1'b0;
            snp_flush <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_foreign) begin
                        r_op    <= bus_op;
                        r_addr  <= bus_addr;
                        r_state <= LOOKUP;
                    end else if (bus_valid) begin
                        bus_ack <= 1'b1;
                        r_state <= ACK;
                    end
                end
                LOOKUP: begin
                    if (w_hit && (tag_rd_state == MODIFIED) && (r_op != INVALIDATE)) begin
                        wb_req  <= 1'b1;
                        wb_addr <= r_addr;
                        wb_data <= tag_rd_data;
                        r_pend  <= (r_op == READ_MISS) ? SHARED : INVALID;
                        r_state <= WB;
                    end else begin
                        bus_ack <= 1'b1;
                        snp_hit <= w_hit;
                        r_state <= ACK;
                    end
                end
                WB: begin
                    if (wb_ack) begin
                        wb_req    <= 1'b0;
                        bus_ack   <= 1'b1;
                        snp_hit   <= 1'b1;
                        snp_flush <= 1'b1;
                        r_state   <= ACK;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SNOOP_STATS_EN
    snoop_stat_ctr u_hit_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus_ack && snp_hit),
        .count (stat_hits)
    );

    snoop_stat_ctr u_flush_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus_ack && snp_flush),
        .count (stat_flushes)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_snoop_responder.sv
// ============================================================================
// Module      : tb_cache_snoop_responder
// Description : Directed, table-driven self-checking bench for the snoop responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_snoop_responder;
    import cache_snoop_responder_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               bus_valid;
    bus_op_t            bus_op;
    logic [15:0]        bus_addr;
    logic [1:0]         bus_src_id;
    logic               bus_ack, snp_hit, snp_flush, snp_busy;
    logic               tag_rd_en;
    logic [3:0]         tag_rd_idx;
    logic [11:0]        tag_rd_tag;
    cache_block_state_t tag_rd_state;
    logic [15:0]        tag_rd_data;
    logic               st_wr_en;
    logic [3:0]         st_wr_idx;
    cache_block_state_t st_wr_state;
    logic               wb_req;
    logic [15:0]        wb_addr, wb_data;
    logic               wb_ack;
    logic               err_proto;
`ifdef SNOOP_STATS_EN
    logic [15:0]        stat_hits, stat_flushes;
`endif

    always #5 clk = ~clk;

    cache_snoop_responder #(.INDEX_W(4), .TAG_W(12), .CORE_ID(2'd0)) dut (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_op(bus_op),
        .bus_addr(bus_addr), .bus_src_id(bus_src_id), .bus_ack(bus_ack),
        .snp_hit(snp_hit), .snp_flush(snp_flush), .snp_busy(snp_busy),
        .tag_rd_en(tag_rd_en), .tag_rd_idx(tag_rd_idx), .tag_rd_tag(tag_rd_tag),
        .tag_rd_state(tag_rd_state), .tag_rd_data(tag_rd_data),
        .st_wr_en(st_wr_en), .st_wr_idx(st_wr_idx), .st_wr_state(st_wr_state),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
        .err_proto(err_proto)
`ifdef SNOOP_STATS_EN
        , .stat_hits(stat_hits), .stat_flushes(stat_flushes)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [1:0]  src;
        logic [11:0] rtag;
        logic [1:0]  rstate;
        logic [15:0] rdata;
        int          dly;
        int          lat;
        logic        hit;
        logic        flush;
        logic        wr;
        logic [1:0]  wrst;
        logic        err;
        logic        wb;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_flushes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int         lat = 0, wr_cnt = 0, err_cnt = 0, wb_cyc = 0;
        logic [1:0] wr_st = 2'd0;
        logic [3:0] wr_idx = 4'd0, ridx;
        logic [15:0] wba = 16'd0, wbd = 16'd0;
        logic       rden, overlap = 1'b0, hit = 1'b0, fl = 1'b0;
        logic       foreign;
        foreign = (v.op != 2'd0) && (v.src != 2'd0);
        @(posedge clk); #1;
        bus_valid    = 1'b1;
        bus_op       = bus_op_t'(v.op);
        bus_addr     = v.addr;
        bus_src_id   = v.src;
        tag_rd_tag   = v.rtag;
        tag_rd_state = cache_block_state_t'(v.rstate);
        tag_rd_data  = v.rdata;
        #1;
        rden = tag_rd_en;
        ridx = tag_rd_idx;
        @(posedge clk);
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            wb_ack = wb_req && (wb_cyc >= v.dly);
            #1;
            if (wb_req) begin wb_cyc++; wba = wb_addr; wbd = wb_data; end
            if (st_wr_en) begin
                wr_cnt++; wr_st = st_wr_state; wr_idx = st_wr_idx;
                if (bus_ack) overlap = 1'b1;
            end
            if (err_proto) err_cnt++;
            if (bus_ack) begin lat = c; hit = snp_hit; fl = snp_flush; bus_valid = 1'b0; end
        end
        wb_ack    = 1'b0;
        bus_valid = 1'b0;
        chk($sformatf("v%0d tag_rd_en", k), rden, foreign);
        if (foreign) chk($sformatf("v%0d tag_rd_idx", k), ridx, v.addr[3:0]);
        chk($sformatf("v%0d ack_latency", k), lat, v.lat);
        chk($sformatf("v%0d snp_hit", k), hit, v.hit);
        chk($sformatf("v%0d snp_flush", k), fl, v.flush);
        chk($sformatf("v%0d st_wr_count", k), wr_cnt, v.wr ? 1 : 0);
        if (v.wr) begin
            chk($sformatf("v%0d st_wr_state", k), wr_st, v.wrst);
            chk($sformatf("v%0d st_wr_idx", k), wr_idx, v.addr[3:0]);
        end
        chk($sformatf("v%0d err_proto", k), err_cnt, v.err ? 1 : 0);
        chk($sformatf("v%0d wb_cycles", k), wb_cyc, v.wb ? v.dly + 1 : 0);
        if (v.wb) begin
            chk($sformatf("v%0d wb_addr", k), wba, v.addr);
            chk($sformatf("v%0d wb_data", k), wbd, v.rdata);
        end
        chk($sformatf("v%0d wr_with_ack", k), overlap, 1'b0);
        if (v.hit) exp_hits++;
        if (v.flush) exp_flushes++;
    endtask

    vec_t vecs[10];

    initial begin
        int seen;
        int wr_seen;
        // op, addr, src, tag, state, data, dly, lat, hit, flush, wr, wrst, err, wb
        vecs[0] = '{2'd1, 16'h0123, 2'd1, 12'h012, 2'd2, 16'hBEEF, 0, 3, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[1] = '{2'd2, 16'h0045, 2'd2, 12'h004, 2'd1, 16'h0000, 0, 2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{2'd1, 16'h0045, 2'd3, 12'h005, 2'd2, 16'h1111, 0, 2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[3] = '{2'd1, 16'h0123, 2'd0, 12'h012, 2'd2, 16'h2222, 0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[4] = '{2'd3, 16'h0ABC, 2'd1, 12'h0AB, 2'd2, 16'h3333, 0, 2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[5] = '{2'd1, 16'h0077, 2'd2, 12'h007, 2'd1, 16'h4444, 0, 2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[6] = '{2'd2, 16'hFFF0, 2'd1, 12'hFFF, 2'd2, 16'h1234, 2, 5, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[7] = '{2'd0, 16'h0123, 2'd1, 12'h012, 2'd2, 16'h5555, 0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[8] = '{2'd2, 16'h0045, 2'd1, 12'h004, 2'd0, 16'h6666, 0, 2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[9] = '{2'd3, 16'h1002, 2'd3, 12'h100, 2'd1, 16'h7777, 0, 2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};

        rst = 1'b1; bus_valid = 1'b0; bus_op = NOOP; bus_addr = '0; bus_src_id = '0;
        tag_rd_tag = '0; tag_rd_state = INVALID; tag_rd_data = '0; wb_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset bus_ack", bus_ack, 1'b0);
        chk("reset snp_busy", snp_busy, 1'b0);
        chk("reset wb_req", wb_req, 1'b0);
        chk("reset st_wr_en", st_wr_en, 1'b0);
        chk("reset outputs", {snp_hit, snp_flush, err_proto, tag_rd_en, wb_addr, wb_data}, 0);
`ifdef SNOOP_STATS_EN
        chk("reset stat_hits", stat_hits, 16'd0);
        chk("reset stat_flushes", stat_flushes, 16'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        @(posedge clk); #1;
        chk("idle snp_busy", snp_busy, 1'b0);
`ifdef SNOOP_STATS_EN
        chk("stat_hits", stat_hits, exp_hits);
        chk("stat_flushes", stat_flushes, exp_flushes);
`endif

        // Reset during a stalled writeback
        @(posedge clk); #1;
        bus_valid = 1'b1; bus_op = READ_MISS; bus_addr = 16'h0123; bus_src_id = 2'd1;
        tag_rd_tag = 12'h012; tag_rd_state = MODIFIED; tag_rd_data = 16'hBEEF;
        seen = 0;
        wr_seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (wb_req) seen = 1;
        end
        chk("rstwb wb_req_rise", seen, 1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rstwb hold%0d wb_req", c), wb_req, 1'b1);
            chk($sformatf("rstwb hold%0d wb_addr", c), wb_addr, 16'h0123);
            chk($sformatf("rstwb hold%0d wb_data", c), wb_data, 16'hBEEF);
            if (st_wr_en || bus_ack) wr_seen++;
            @(negedge clk);
        end
        #2;
        rst = 1'b1; bus_valid = 1'b0;
        #1;
        chk("rstwb wb_req_drop", wb_req, 1'b0);
        chk("rstwb snp_busy", snp_busy, 1'b0);
        chk("rstwb st_wr_en", st_wr_en, 1'b0);
        chk("rstwb no_write_or_ack", wr_seen, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstwb idle_after", {snp_busy, wb_req, bus_ack}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_snoop_responder.md
# cache_snoop_responder

Per-core snoop side of the shared-memory coherence bus. Watches bus operations issued by other cores' cache controllers (`NOOP`, `READ_MISS`, `WRITE_MISS`, `INVALIDATE`) and looks up the local direct-mapped cache tag/state array. It downgrades or invalidates the matching block (`SHARED`/`MODIFIED`/`INVALID`), writes back dirty data to memory when required, then acknowledges the bus. It sits between the coherence bus and the local cache's snoop port, and it stalls local cache accesses while busy.

## Interface
- `INDEX_W`, 4: cache index width. Cache has 2^INDEX_W one-word blocks.
- `TAG_W`, 12: tag width; must equal 16 − INDEX_W.
- `CORE_ID`, 0: this core's bus ID; 2-bit value.

- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `bus_valid`  in  1: bus operation present; held by the initiator until `bus_ack`.
- `bus_op`  in  `bus_op_t`: operation code.
- `bus_addr`  in  16: word address.
- `bus_src_id`  in  2: initiating core.
- `bus_ack`  out  1: one-cycle completion pulse.
- `snp_hit`  out  1: valid with `bus_ack`; the block was present (not `INVALID`).
- `snp_flush`  out  1: valid with `bus_ack`; a writeback occurred.
- `snp_busy`  out  1: high whenever the FSM is not in IDLE; the local cache must stall.
- `tag_rd_en`  out  1: snoop read strobe to the array.
- `tag_rd_idx`  out  INDEX_W: array index.
- `tag_rd_tag`  in  TAG_W: stored tag; valid 1 cycle after `tag_rd_en`.
- `tag_rd_state`  in  `cache_block_state_t`: stored state; same timing as `tag_rd_tag`.
- `tag_rd_data`  in  16: stored data; same timing as `tag_rd_tag`.
- `st_wr_en`  out  1: state write strobe.
- `st_wr_idx`  out  INDEX_W: state write index.
- `st_wr_state`  out  `cache_block_state_t`: state to write.
- `wb_req`  out  1: memory writeback request; held until `wb_ack`.
- `wb_addr`  out  16: writeback address.
- `wb_data`  out  16: writeback data.
- `wb_ack`  in  1: memory accepted the write.
- `err_proto`  out  1: one-cycle pulse when `INVALIDATE` hits a `MODIFIED` block.

## Operation
FSM states: IDLE, LOOKUP, WB, ACK.
- **IDLE**
  - If `bus_valid` and `bus_op`≠`NOOP` and `bus_src_id`≠CORE_ID: capture op and address, pulse `tag_rd_en` with index `bus_addr[INDEX_W-1:0]`, go to LOOKUP.
  - If `bus_valid` and the op is `NOOP` or the source is this core: go straight to ACK with no lookup; `snp_hit`=0, `snp_flush`=0.
- **LOOKUP**
  - hit = (`tag_rd_tag` == captured `addr[15:INDEX_W]`) and `tag_rd_state`≠`INVALID`.
  - Miss: go to ACK, no write.
  - SHARED hit, `READ_MISS`: no change, go to ACK.
  - SHARED hit, `WRITE_MISS` or `INVALIDATE`: write `INVALID`, go to ACK.
  - MODIFIED hit, `READ_MISS`: capture data, go to WB; pending state `SHARED`.
  - MODIFIED hit, `WRITE_MISS`: capture data, go to WB; pending state `INVALID`.
  - MODIFIED hit, `INVALIDATE`: pulse `err_proto`, write `INVALID`, go to ACK with no writeback.
- **WB**: hold `wb_req`, `wb_addr`, `wb_data` stable until `wb_ack`. On the `wb_ack` cycle, write the pending state, set the flush flag, go to ACK.
- **ACK**: pulse `bus_ack`, drive `snp_hit`/`snp_flush`, return to IDLE. `bus_valid` is ignored in ACK. A new op is accepted in IDLE on the following cycle.

## Timing
- Reset values: every output 0; FSM in IDLE; pending state `INVALID`.
- Miss or SHARED hit: `bus_valid` sampled at edge N; `bus_ack` is high in cycle N+2.
- Own-core op or `NOOP`: `bus_ack` in cycle N+1.
- MODIFIED hit: `wb_req` rises in cycle N+2. `bus_ack` comes 1 cycle after the `wb_ack` cycle. `wb_ack` may arrive in the first `wb_req` cycle.
- `st_wr_en` is a single-cycle pulse. It is never asserted in the same cycle as `bus_ack`.
- `snp_busy` is combinational from state ≠ IDLE.
- Reset asserted mid-operation: FSM returns to IDLE immediately. `wb_req` drops and no state write is issued. The initiator must reissue the op.

## Configuration
- `SNOOP_STATS_EN` defined:
  - Adds output ports `stat_hits` [15:0] and `stat_flushes` [15:0].
  - Both are saturating counters, incremented on the `bus_ack` cycle when `snp_hit` or `snp_flush` is set respectively.
  - Cleared by `rst`; saturate at 16'hFFFF.
- `SNOOP_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Add `snoop_fsm_t` {IDLE, LOOKUP, WB, ACK} to the shared `common` package, next to `bus_op_t` and `cache_block_state_t`.
- Sub-module `snoop_stat_ctr`: one 16-bit saturating counter, instantiated twice under `SNOOP_STATS_EN`.

## Test plan
- Foreign `READ_MISS` at 0x0123; array returns tag 0x012, state MODIFIED, data 0xBEEF → `wb_req` with `wb_addr`=0x0123 and `wb_data`=0xBEEF; after `wb_ack`, `st_wr_state`=`SHARED`, then `bus_ack` with `snp_hit`=1, `snp_flush`=1.
- Foreign `WRITE_MISS` at 0x0045; array returns tag 0x004, state SHARED → `st_wr_state`=`INVALID` at index 5; `bus_ack` in cycle N+2 with `snp_flush`=0.
- Foreign `READ_MISS` with a tag mismatch, and a separate op with `bus_src_id`=CORE_ID → no `st_wr_en`; `bus_ack` in N+2 and N+1 respectively; `snp_hit`=0.
- Foreign `INVALIDATE` hitting a MODIFIED block → `err_proto` pulse, `INVALID` written, no `wb_req`.
- `wb_ack` delayed 5 cycles, then `rst` pulsed mid-WB → `wb_req` stable during the wait, then drops to 0 asynchronously; `snp_busy`=0; no `st_wr_en`.
- With `SNOOP_STATS_EN`: 3 hits, 1 flush → `stat_hits`=3, `stat_flushes`=1.
